uart_rx_pack_fifo: RTL
======================

// Module: uart_rx_pack_fifo
// PURPOSE
//  Receive-side FIFO for the wishbone UART. Accepts one byte per cycle from the UART receiver.
//  Hands the bus side up to 4 bytes per read strobe, packed into one 32-bit word.
//  Mirror of the transmit FIFO, which takes multi-byte writes and returns single-byte reads.
// PARAMETERS
//  FIFO_DEPTH_BITS  8  depth = 2**FIFO_DEPTH_BITS bytes; all slots usable
//  ALLOW_OVERFLOW   1  1: write when full overwrites the oldest byte; 0: write when full is dropped
// PORTS
//  clk                 in   1   single clock domain
//  rst                 in   1   asynchronous, active-high reset
//  size                out  32  constant 2**FIFO_DEPTH_BITS
//  write_strobe        in   1   write_data valid this cycle
//  write_data          in   8   received byte
//  write_available     out  32  free slots, registered
//  read_strobe         in   1   pop request
//  read_request_count  in   3   bytes requested; 0 = no-op, 5..7 clamp to 4
//  read_data           out  32  byte0 in [7:0] (oldest) .. byte3 in [31:24]; unfilled lanes 0
//  read_valid_count    out  3   bytes actually returned by the last read (0..4)
//  read_done           out  1   1-cycle pulse: read_data/read_valid_count updated
//  read_count          out  32  occupancy in bytes, registered
//  threshold           in   32  level for threshold_hit (UART_RX_FIFO_THRESHOLD_EN only)
//  threshold_hit       out  1   occupancy >= threshold
//  overflow            out  1   1-cycle pulse
//  underflow           out  1   1-cycle pulse
//  full                out  1   occupancy == size
//  empty               out  1   occupancy == 0
// BEHAVIOUR
//  Reset (async assert, sync release): pointers=0, occupancy=0, read_data=0, read_valid_count=0.
//  Reset values, cont.: read_done/overflow/underflow=0, write_available=size, read_count=0, empty=1, full=0.
//  Storage contents are not reset.
//  Pointers are FIFO_DEPTH_BITS wide and wrap modulo depth.
//  Occupancy counter is FIFO_DEPTH_BITS+1 wide; full/empty derive from it, never from pointer compare.
//  Read grant G = min(clamped request, occupancy before this edge). Latency is 1 cycle.
//  Strobe on edge N -> read_data, read_valid_count=G and read_done valid after edge N+1.
//  Read outputs hold until the next read_done.
//  Read with occupancy 0 and request >0: underflow pulse, read_done pulse, read_valid_count=0, read_data=0.
//  Read byte order is strictly FIFO. Multi-byte reads spanning the pointer wrap return contiguous logical order.
//  Simultaneous write+read: both take effect; a byte written this edge is never in this edge's grant.
//  Occupancy after simultaneous write+read = occ + 1 - G.
//  Write when full with G>=1 in the same cycle: normal write, no overflow.
//  Write when full with G=0, ALLOW_OVERFLOW=1: byte stored at in_ptr, in_ptr and out_ptr both advance, occupancy unchanged, overflow pulse.
//  Write when full with G=0, ALLOW_OVERFLOW=0: byte dropped, nothing changes, overflow pulse.
//  Status outputs (read_count, write_available, full, empty) reflect post-edge state.
//  Status outputs are registered, with 0-cycle lag after the updating edge.
//  Reset mid-read: the pending read_done is cancelled; the FIFO is empty after release.
// CONFIGURATION
//  Macro UART_RX_FIFO_THRESHOLD_EN.
//  Defined: threshold_hit registered, = (post-edge occupancy >= threshold) && threshold != 0; reset 0.
//  Undefined: threshold_hit tied to 0, threshold input ignored. All other behaviour is identical.
// STRUCTURE
//  Shared package uart_fifo_pkg: UART_LANES=4, lane-count width (3), byte width (8).
//  Shared package, cont.: clamp function for requested count, 32-bit status width.
//  Sub-module uart_fifo_ram: 1 write port, 4 combinational read ports at out_ptr+0..3. No reset on storage.
//  This block holds the pointers, occupancy counter, grant logic, output pack register and flags.
// TESTING
//  1. Reset, FIFO_DEPTH_BITS=3 -> size=8, write_available=8, empty=1, read_done=0.
//  2. Write 0x11,0x22,0x33; read req 4 -> next cycle read_data=0x00332211, read_valid_count=3, empty=1.
//  3. Empty FIFO, read req 2 -> underflow pulse, read_done pulse, read_valid_count=0, read_data=0.
//  4. Depth 8: fill 0x00..0x07, write 0x08 with no read.
//  4, cont.: ALLOW_OVERFLOW=1 -> overflow pulse, read req 4 returns 0x04030201.
//  4, cont.: ALLOW_OVERFLOW=0 -> overflow pulse, read req 4 returns 0x03020100.
//  5. Occupancy 6 with out_ptr=6; read req 4 together with write 0xAA -> G=4, bytes from slots 6,7,0,1.
//  5, cont.: Result is read_count=3, no overflow.
//  6. With UART_RX_FIFO_THRESHOLD_EN, threshold=2: write 2 bytes -> threshold_hit=1.
//  6, cont.: Read 1 byte -> threshold_hit=0. Without the macro threshold_hit stays 0.

Source files
------------

// File: rtl/uart_rx_pack_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_pkg
// Shared definitions for the wishbone UART FIFOs: byte and lane widths, the
// 32-bit status width, and the helper that clamps a requested byte count to
// the number of lanes in one bus word.
// ---------------------------------------------------------------------------
package uart_fifo_pkg;

    localparam int UART_LANES = 4;
    localparam int LANE_CNT_W = 3;
    localparam int BYTE_W     = 8;
    localparam int STATUS_W   = 32;

    typedef logic [BYTE_W-1:0]     byte_t;
    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;
    typedef logic [STATUS_W-1:0]   status_t;

    // Requests of 5..7 bytes are trimmed to one full bus word.
    function automatic lane_cnt_t clamp_request(input lane_cnt_t req);
        return (req > lane_cnt_t'(UART_LANES)) ? lane_cnt_t'(UART_LANES) : req;
    endfunction

endpackage

// File: rtl/uart_rx_pack_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_pack_fifo_if
// Bundles the byte-write side, the packed word-read side and the status
// flags of the receive FIFO.
//   master : the UART receiver / bus side (drives strobes, data, threshold)
//   slave  : the FIFO itself (drives read data, status and event pulses)
// ---------------------------------------------------------------------------
interface uart_rx_pack_fifo_if;
    import uart_fifo_pkg::*;

    status_t   size;
    logic      write_strobe;
    byte_t     write_data;
    status_t   write_available;
    logic      read_strobe;
    lane_cnt_t read_request_count;
    status_t   read_data;
    lane_cnt_t read_valid_count;
    logic      read_done;
    status_t   read_count;
    status_t   threshold;
    logic      threshold_hit;
    logic      overflow;
    logic      underflow;
    logic      full;
    logic      empty;

    modport master (
        output write_strobe, write_data, read_strobe, read_request_count, threshold,
        input  size, write_available, read_data, read_valid_count, read_done,
               read_count, threshold_hit, overflow, underflow, full, empty
    );

    modport slave (
        input  write_strobe, write_data, read_strobe, read_request_count, threshold,
        output size, write_available, read_data, read_valid_count, read_done,
               read_count, threshold_hit, overflow, underflow, full, empty
    );

endinterface

// File: rtl/uart_rx_pack_fifo_ram.sv
// ---------------------------------------------------------------------------
// uart_fifo_ram
// Byte storage for the receive FIFO: one synchronous write port and
// UART_LANES combinational read ports at rd_base+0 .. rd_base+3 (wrapping).
// Storage is deliberately not reset.
// Ports:
//   clk     : clock
//   wr_en   : write wr_data into mem[wr_addr] on this edge
//   wr_addr : write slot
//   wr_data : byte to store
//   rd_base : slot of the oldest byte (lane 0)
//   rd_data : lane i = mem[rd_base + i]
// ---------------------------------------------------------------------------
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH_BITS = 8
) (
    input  logic                                clk,
    input  logic                                wr_en,
    input  logic [DEPTH_BITS-1:0]               wr_addr,
    input  byte_t                               wr_data,
    input  logic [DEPTH_BITS-1:0]               rd_base,
    output logic [UART_LANES-1:0][BYTE_W-1:0]   rd_data
);

    byte_t mem [2**DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Address arithmetic wraps naturally at the pointer width, so a
    // multi-byte read across the end of the array stays in logical order.
    for (genvar i = 0; i < UART_LANES; i++) begin : g_rd_port
        assign rd_data[i] = mem[rd_base + DEPTH_BITS'(i)];
    end

endmodule

// File: rtl/uart_rx_pack_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_pack_fifo
// Receive-side FIFO for the wishbone UART. Takes one byte per cycle from the
// receiver and returns up to four bytes per read strobe packed into a 32-bit
// word (oldest byte in [7:0], unfilled lanes zero).
// Parameters:
//   FIFO_DEPTH_BITS : depth = 2**FIFO_DEPTH_BITS bytes, all usable
//   ALLOW_OVERFLOW  : 1 = write when full replaces the oldest byte,
//                     0 = write when full is dropped
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_rx_pack_fifo_if.slave (write, packed read, status)
// Configuration macro UART_RX_FIFO_THRESHOLD_EN: when defined, threshold_hit
// is a registered (occupancy >= threshold && threshold != 0); otherwise it is
// tied low and the threshold input is ignored.
// ---------------------------------------------------------------------------
module uart_rx_pack_fifo
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH_BITS = 8,
    parameter bit ALLOW_OVERFLOW  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    uart_rx_pack_fifo_if.slave bus
);

    localparam int DEPTH = 2**FIFO_DEPTH_BITS;

    typedef logic [FIFO_DEPTH_BITS:0]   occ_t;
    typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;

    localparam occ_t DEPTH_OCC = occ_t'(DEPTH);

    ptr_t      in_ptr;
    ptr_t      out_ptr;
    occ_t      occ;
    occ_t      occ_next;
    lane_cnt_t req_clamped;
    lane_cnt_t grant;
    logic      rd_en;
    logic      is_full;
    logic      wr_accept;
    logic      ovf_event;
    logic      ovf_shift;
    logic      wr_store;
    status_t   packed_data;
    logic [UART_LANES-1:0][BYTE_W-1:0] lane_data;

    assign bus.size = status_t'(DEPTH);

    uart_fifo_ram #(
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_store),
        .wr_addr (in_ptr),
        .wr_data (bus.write_data),
        .rd_base (out_ptr),
        .rd_data (lane_data)
    );

    // Grant is bounded by the occupancy before this edge, so a byte written
    // on the same edge can never be part of this read. When full, a nonzero
    // grant frees room, so the write is accepted normally. Only a write into
    // a full FIFO with no read counts as overflow.
    always_comb begin
        req_clamped = clamp_request(bus.read_request_count);
        rd_en       = bus.read_strobe && (req_clamped != '0);
        grant       = '0;
        if (rd_en) begin
            grant = (occ_t'(req_clamped) < occ) ? req_clamped : lane_cnt_t'(occ);
        end
        is_full   = (occ == DEPTH_OCC);
        wr_accept = bus.write_strobe && (!is_full || (grant != '0));
        ovf_event = bus.write_strobe && is_full && (grant == '0);
        ovf_shift = ovf_event && ALLOW_OVERFLOW;
        wr_store  = wr_accept || ovf_shift;
        occ_next  = occ + occ_t'(wr_accept) - occ_t'(grant);

        packed_data = '0;
        for (int i = 0; i < UART_LANES; i++) begin
            if (lane_cnt_t'(i) < grant) begin
                packed_data[i*BYTE_W +: BYTE_W] = lane_data[i];
            end
        end
    end

    // Status is registered from occ_next so it matches the post-edge state
    // with no extra lag. An overflow with ALLOW_OVERFLOW advances both
    // pointers, discarding the oldest byte while occupancy stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ptr                <= '0;
            out_ptr               <= '0;
            occ                   <= '0;
            bus.read_data         <= '0;
            bus.read_valid_count  <= '0;
            bus.read_done         <= 1'b0;
            bus.overflow          <= 1'b0;
            bus.underflow         <= 1'b0;
            bus.read_count        <= '0;
            bus.write_available   <= status_t'(DEPTH);
            bus.full              <= 1'b0;
            bus.empty             <= 1'b1;
        end else begin
            if (wr_store) begin
                in_ptr <= in_ptr + 1'b1;
            end
            out_ptr <= out_ptr + ptr_t'(grant) + ptr_t'(ovf_shift);
            occ     <= occ_next;

            bus.read_done <= rd_en;
            bus.underflow <= rd_en && (occ == '0);
            bus.overflow  <= ovf_event;
            if (rd_en) begin
                bus.read_data        <= packed_data;
                bus.read_valid_count <= grant;
            end

            bus.read_count      <= status_t'(occ_next);
            bus.write_available <= status_t'(DEPTH_OCC - occ_next);
            bus.full            <= (occ_next == DEPTH_OCC);
            bus.empty           <= (occ_next == '0);
        end
    end

`ifdef UART_RX_FIFO_THRESHOLD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.threshold_hit <= 1'b0;
        end else begin
            bus.threshold_hit <= (status_t'(occ_next) >= bus.threshold) &&
                                 (bus.threshold != '0);
        end
    end
`else
    logic unused_threshold;
    assign unused_threshold  = ^bus.threshold;
    assign bus.threshold_hit = 1'b0;
`endif

endmodule
